r_control_sync: RTL and testbench
=================================

// Module: r_control_sync
// PURPOSE
//  Read-side pointer/flag controller of the asynchronous FIFO; counterpart of the write-side controller.
//  Keeps the binary read address for the dual-port RAM and publishes a Gray read pointer to the write domain.
//  Brings the write-domain Gray pointer into the read domain through a 2-flop synchronizer.
//  Generates a registered, pessimistic rempty flag. Runs entirely on rclk; no logic is shared with the write side.
// PARAMETERS
//  DATASIZE   8  RAM word width; carried for interface uniformity, no logic depends on it
//  ADDSIZE    8  RAM address width; depth = 2**ADDSIZE; pointers are ADDSIZE+1 bits (extra wrap bit)
//  AEMPTY_TH  4  almost-empty threshold in words (used only with RCTRL_LEVEL_EN)
// PORTS
//  rclk           in   1          read clock
//  rrst           in   1          synchronous reset, active-high
//  rinc           in   1          read request; honoured only when rempty==0
//  wptr           in   ADDSIZE+1  Gray write pointer from write domain (asynchronous to rclk)
//  raddr          out  ADDSIZE    RAM read address = rbin[ADDSIZE-1:0]
//  rptr           out  ADDSIZE+1  registered Gray read pointer, to write domain
//  ren            out  1          RAM read enable = rinc & ~rempty (combinational)
//  rempty         out  1          FIFO empty, registered
//  rlevel         out  ADDSIZE+1  words available (RCTRL_LEVEL_EN only)
//  ralmost_empty  out  1          rlevel <= AEMPTY_TH (RCTRL_LEVEL_EN only)
// BEHAVIOUR
//  - Reset (rrst=1 at posedge rclk): rbin=0, rptr=0, wq1=wq2=0, rempty=1, raddr=0; rlevel=0, ralmost_empty=1.
//    A mid-operation reset discards all pointer state. The system resets both domains together.
//  - Synchronizer: wq1<=wptr; wq2<=wq1. There is no other use of wptr.
//  - rbin_next = rbin + (rinc & ~rempty), computed modulo 2**(ADDSIZE+1).
//  - rgray_next = (rbin_next>>1) ^ rbin_next.
//  - Each rclk cycle: rbin<=rbin_next; rptr<=rgray_next; rempty<=(rgray_next==wq2).
//  - rinc while rempty=1: ignored. ren=0 and rbin/rptr are unchanged. This never underflows.
//  - Read latency: raddr presents word N in the cycle ren is asserted. RAM data timing belongs to the RAM, not this block.
//  - Empty latency: a wptr change at the input deasserts rempty after 3 rclk edges (2 sync + flag register).
//  - Becoming empty is immediate: the read of the last word sets rempty at the same edge that advances rbin.
//  - Wrap: rbin 2**ADDSIZE-1 -> 2**ADDSIZE gives raddr=0 and flips the MSB. Full equality of ADDSIZE+1 bits means empty.
//  - rptr changes by exactly one Gray bit per increment. The write side relies on this for safe synchronization.
//  - rempty is pessimistic: it may stay 1 up to 3 cycles after data arrives, and it is never 0 while the FIFO is empty.
// CONFIGURATION
//  Macro RCTRL_LEVEL_EN.
//  Defined:
//   - wq2_bin = gray-to-binary(wq2).
//   - rlevel <= wq2_bin - rbin_next (mod 2**(ADDSIZE+1)).
//   - ralmost_empty <= (wq2_bin - rbin_next) <= AEMPTY_TH.
//   - Both are registered in the same cycle as rempty, so rlevel==0 exactly when rempty==1.
//  Not defined: rlevel and ralmost_empty ports are absent, and no level logic is built.
// TESTING (ADDSIZE=8, AEMPTY_TH=4)
//  1. Assert rrst 2 cycles, wptr=0 -> rempty=1, rptr=9'h000, raddr=0, ren=0; with RCTRL_LEVEL_EN: rlevel=0, ralmost_empty=1.
//  2. Hold wptr=9'h001 from cycle 0 -> rempty=0 at edge 3.
//     Pulse rinc 1 cycle -> ren=1 that cycle; next edge: raddr=1, rptr=9'h001, rempty=1.
//  3. Keep rinc=1 with wptr static and rempty=1 for 10 cycles -> ren=0, raddr and rptr unchanged.
//  4. Wrap: step wptr Gray 0..256 while reading continuously for 256 reads.
//     -> raddr 255->0, rptr=9'h180 after read 256, then rempty=1.
//     Check rptr changes by 1 bit per step.
//  5. (RCTRL_LEVEL_EN) wptr=9'h00F (bin 10) -> after 3 edges rlevel=10, ralmost_empty=0.
//     Read 6 -> rlevel=4, ralmost_empty=1. Read 4 -> rlevel=0, rempty=1.
//  6. Assert rrst mid-stream with rbin=37 -> next edge: rbin=0, rptr=0, rempty=1.
//     After release, rempty tracks wq2 against pointer 0.

Source files
------------

// File: rtl/r_control_sync_if.sv
// Read-side controller bundle: read request, write pointer in, addresses/pointers/flags out.
// Optional level outputs exist only when RCTRL_LEVEL_EN is defined.
interface r_control_sync_if #(
  parameter int unsigned ADDSIZE = 8
);
  logic               rinc;
  logic [ADDSIZE:0]   wptr;
  logic [ADDSIZE-1:0] raddr;
  logic [ADDSIZE:0]   rptr;
  logic               ren;
  logic               rempty;
`ifdef RCTRL_LEVEL_EN
  logic [ADDSIZE:0]   rlevel;
  logic               ralmost_empty;
`endif

  // Drives requests and the foreign write pointer; observes the controller.
  modport master (
    output rinc,
    output wptr,
    input  raddr,
    input  rptr,
    input  ren,
    input  rempty
`ifdef RCTRL_LEVEL_EN
    ,
    input  rlevel,
    input  ralmost_empty
`endif
  );

  // The read-side controller itself.
  modport slave (
    input  rinc,
    input  wptr,
    output raddr,
    output rptr,
    output ren,
    output rempty
`ifdef RCTRL_LEVEL_EN
    ,
    output rlevel,
    output ralmost_empty
`endif
  );
endinterface

// File: rtl/r_control_sync.sv
// Read-side pointer/flag controller of an asynchronous FIFO, clocked entirely on rclk.
// Keeps the binary read address, publishes a Gray read pointer, synchronizes the Gray write
// pointer through two flops and registers a pessimistic empty flag.
// Optional macro RCTRL_LEVEL_EN adds registered rlevel / ralmost_empty outputs.
module r_control_sync #(
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned ADDSIZE   = 8,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic            rclk_i,
  input  logic            rrst_i,
  r_control_sync_if.slave bus
);

  // Reject configurations that cannot describe a real FIFO at elaboration time.
  if (DATASIZE < 1 || ADDSIZE < 1 || AEMPTY_TH > (1 << ADDSIZE)) begin : g_param_check
    $error("r_control_sync: invalid DATASIZE/ADDSIZE/AEMPTY_TH");
  end

  logic [ADDSIZE:0] rbin_q, rbin_d;
  logic [ADDSIZE:0] rptr_q, rptr_d;
  logic [ADDSIZE:0] wq1_q, wq2_q;
  logic             rempty_q, rempty_d;
  logic             ren;

  // A read is honoured only while not empty, so the pointer can never underflow.
  assign ren = bus.rinc & ~rempty_q;

  // Next binary/Gray pointers and the empty decision made against the synchronized write pointer.
  always_comb begin
    rbin_d   = rbin_q + {{ADDSIZE{1'b0}}, ren};
    rptr_d   = (rbin_d >> 1) ^ rbin_d;
    rempty_d = (rptr_d == wq2_q);
  end

  // Pointer, synchronizer and flag state; everything clears together on reset.
  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      wq1_q    <= '0;
      wq2_q    <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      wq1_q    <= bus.wptr;
      wq2_q    <= wq1_q;
      rempty_q <= rempty_d;
    end
  end

  // Drive the bundle outputs from registered state.
  always_comb begin
    bus.raddr  = rbin_q[ADDSIZE-1:0];
    bus.rptr   = rptr_q;
    bus.ren    = ren;
    bus.rempty = rempty_q;
  end

`ifdef RCTRL_LEVEL_EN
  logic [ADDSIZE:0] wq2_bin;
  logic [ADDSIZE:0] rlevel_q, rlevel_d;
  logic             raempty_q, raempty_d;

  // Level is computed against the post-read pointer so it lines up with rempty.
  always_comb begin
    wq2_bin = '0;
    for (int i = 0; i <= int'(ADDSIZE); i++) begin
      wq2_bin[i] = ^(wq2_q >> i);
    end
    rlevel_d  = wq2_bin - rbin_d;
    raempty_d = (rlevel_d <= (ADDSIZE + 1)'(AEMPTY_TH));
  end

  // Level registers share the flag's timing so rlevel==0 exactly when rempty==1.
  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      rlevel_q  <= '0;
      raempty_q <= 1'b1;
    end else begin
      rlevel_q  <= rlevel_d;
      raempty_q <= raempty_d;
    end
  end

  // Publish level outputs.
  always_comb begin
    bus.rlevel        = rlevel_q;
    bus.ralmost_empty = raempty_q;
  end
`endif

endmodule

// File: tb/tb_r_control_sync.sv
// Self-checking bench for r_control_sync (ADDSIZE=8, AEMPTY_TH=4). Expected read addresses
// are queued when reads are requested and popped when the DUT asserts ren.
module tb_r_control_sync;

  localparam int unsigned AW = 8;

  logic clk;
  logic rrst;
  int   total;
  int   bad;
  logic [AW-1:0] exp_q[$];
  logic          chk_gray;
  logic [AW:0]   prev_rptr;

  r_control_sync_if #(.ADDSIZE(AW)) bus ();

  r_control_sync #(
    .DATASIZE (8),
    .ADDSIZE  (AW),
    .AEMPTY_TH(4)
  ) dut (
    .rclk_i(clk),
    .rrst_i(rrst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every honoured read must match the next queued address.
  always @(negedge clk) begin
    if (!rrst && bus.ren === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL read_unexpected: ren=1 raddr=%0d, required no read", bus.raddr);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (bus.raddr !== e) begin
          bad++;
          $display("FAIL read_addr: raddr=%0d required=%0d", bus.raddr, e);
        end
      end
    end
    if (chk_gray) begin
      total++;
      if ($countones(bus.rptr ^ prev_rptr) > 1) begin
        bad++;
        $display("FAIL gray_step: rptr %h -> %h, required at most one bit change",
                 prev_rptr, bus.rptr);
      end
    end
    prev_rptr = bus.rptr;
  end

  task automatic do_reset();
    rrst     = 1'b1;
    bus.rinc = 1'b0;
    bus.wptr = '0;
    tick();
    tick();
    rrst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.rempty !== 1'b1 || bus.rptr !== 9'h000 || bus.raddr !== 8'd0 || bus.ren !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rempty=%b rptr=%h raddr=%0d ren=%b required 1/000/0/0",
               bus.rempty, bus.rptr, bus.raddr, bus.ren);
    end
`ifdef RCTRL_LEVEL_EN
    total++;
    if (bus.rlevel !== 9'd0 || bus.ralmost_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_level: rlevel=%0d ralmost_empty=%b required 0/1",
               bus.rlevel, bus.ralmost_empty);
    end
`endif
  endtask

  task automatic test_first_word();
    do_reset();
    bus.wptr = 9'h001;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (bus.rempty !== (e < 3 ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL empty_latency: edge %0d rempty=%b required %b", e, bus.rempty, e < 3);
      end
    end
    bus.rinc = 1'b1;
    exp_q.push_back(8'd0);
    #1;
    total++;
    if (bus.ren !== 1'b1) begin
      bad++;
      $display("FAIL first_ren: ren=%b required 1", bus.ren);
    end
    tick();
    bus.rinc = 1'b0;
    total++;
    if (bus.raddr !== 8'd1 || bus.rptr !== 9'h001 || bus.rempty !== 1'b1) begin
      bad++;
      $display("FAIL first_read: raddr=%0d rptr=%h rempty=%b required 1/001/1",
               bus.raddr, bus.rptr, bus.rempty);
    end
  endtask

  task automatic test_underflow();
    bus.rinc = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (bus.ren !== 1'b0) begin
        bad++;
        $display("FAIL underflow_ren: cycle %0d ren=%b required 0", c, bus.ren);
      end
      tick();
      total++;
      if (bus.raddr !== 8'd1 || bus.rptr !== 9'h001 || bus.rempty !== 1'b1) begin
        bad++;
        $display("FAIL underflow_hold: cycle %0d raddr=%0d rptr=%h rempty=%b required 1/001/1",
                 c, bus.raddr, bus.rptr, bus.rempty);
      end
    end
    bus.rinc = 1'b0;
  endtask

  task automatic test_wrap();
    int wait_cyc;
    do_reset();
    for (int a = 0; a < 256; a++) exp_q.push_back(AW'(a));
    prev_rptr = bus.rptr;
    chk_gray  = 1'b1;
    bus.rinc  = 1'b1;
    for (int w = 1; w <= 256; w++) begin
      bus.wptr = to_gray(9'(w));
      tick();
    end
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_drain: %0d reads outstanding, required 0", exp_q.size());
    end
    tick();
    total++;
    if (bus.rptr !== 9'h180 || bus.raddr !== 8'd0 || bus.rempty !== 1'b1 || bus.ren !== 1'b0) begin
      bad++;
      $display("FAIL wrap_end: rptr=%h raddr=%0d rempty=%b ren=%b required 180/0/1/0",
               bus.rptr, bus.raddr, bus.rempty, bus.ren);
    end
    bus.rinc = 1'b0;
    chk_gray = 1'b0;
  endtask

`ifdef RCTRL_LEVEL_EN
  task automatic test_level();
    do_reset();
    bus.wptr = 9'h00F;
    tick();
    tick();
    tick();
    total++;
    if (bus.rlevel !== 9'd10 || bus.ralmost_empty !== 1'b0 || bus.rempty !== 1'b0) begin
      bad++;
      $display("FAIL level_10: rlevel=%0d ae=%b rempty=%b required 10/0/0",
               bus.rlevel, bus.ralmost_empty, bus.rempty);
    end
    bus.rinc = 1'b1;
    for (int a = 0; a < 6; a++) begin
      exp_q.push_back(AW'(a));
      tick();
    end
    bus.rinc = 1'b0;
    total++;
    if (bus.rlevel !== 9'd4 || bus.ralmost_empty !== 1'b1) begin
      bad++;
      $display("FAIL level_4: rlevel=%0d ae=%b required 4/1", bus.rlevel, bus.ralmost_empty);
    end
    bus.rinc = 1'b1;
    for (int a = 6; a < 10; a++) begin
      exp_q.push_back(AW'(a));
      tick();
    end
    bus.rinc = 1'b0;
    total++;
    if (bus.rlevel !== 9'd0 || bus.rempty !== 1'b1) begin
      bad++;
      $display("FAIL level_0: rlevel=%0d rempty=%b required 0/1", bus.rlevel, bus.rempty);
    end
  endtask
`endif

  task automatic test_midreset();
    do_reset();
    bus.wptr = to_gray(9'd50);
    tick();
    tick();
    tick();
    bus.rinc = 1'b1;
    for (int a = 0; a < 37; a++) begin
      exp_q.push_back(AW'(a));
      tick();
    end
    bus.rinc = 1'b0;
    total++;
    if (bus.raddr !== 8'd37) begin
      bad++;
      $display("FAIL midreset_pre: raddr=%0d required 37", bus.raddr);
    end
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    total++;
    if (bus.raddr !== 8'd0 || bus.rptr !== 9'h000 || bus.rempty !== 1'b1) begin
      bad++;
      $display("FAIL midreset: raddr=%0d rptr=%h rempty=%b required 0/000/1",
               bus.raddr, bus.rptr, bus.rempty);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (bus.rempty !== (e < 3 ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL midreset_track: edge %0d rempty=%b required %b", e, bus.rempty, e < 3);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    chk_gray  = 1'b0;
    prev_rptr = '0;
    rrst      = 1'b1;
    bus.rinc  = 1'b0;
    bus.wptr  = '0;
    test_reset();
    test_first_word();
    test_underflow();
    test_wrap();
`ifdef RCTRL_LEVEL_EN
    test_level();
`endif
    test_midreset();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
